edge_detect_2d: RTL

Parametrised streaming edge detector for RGB565 video. Converts each accepted pixel to 8-bit grayscale and computes horizontal and/or vertical absolute gradients using a one-line buffer. Thresholds the selected magnitude and emits a binary RGB565 edge map with frame and line markers. Sits between the camera/pixel source and the frame-buffer/display writer, in the same slot as the earlier horizontal-only detector.

---
 rtl/edge_pkg.sv | 48 ++++
 rtl/edge_line_buf.sv | 24 ++
 rtl/edge_detect_2d.sv | 137 +++++++++++++
 3 files changed

// File: rtl/edge_pkg.sv
// edge_detect_2d shared types, constants and helpers.
// Gray conversion coefficients, mode codes, stage-1 bundle.
package edge_pkg;

   localparam logic [15:0] R_COEF = 16'd77;
   localparam logic [15:0] G_COEF = 16'd150;
   localparam logic [15:0] B_COEF = 16'd29;

   localparam logic [15:0] PIX_WHITE = 16'hFFFF;
   localparam logic [15:0] PIX_BLACK = 16'h0000;

   typedef enum logic [1:0] {
      MODE_H   = 2'd0,
      MODE_V   = 2'd1,
      MODE_SUM = 2'd2,
      MODE_MAX = 2'd3
   } mode_e;

   typedef struct packed {
      logic       valid;
      logic [7:0] gray;
      logic [7:0] left;
      logic       x0;
      logic       y0;
      logic       sof;
      logic       eol;
   } s1_t;

   // Operands are widened to 16 bits; the sum of the
   // weighted channels never exceeds 16 bits.
   function automatic logic [7:0] rgb_to_gray(
      input logic [15:0] p
   );
      logic [15:0] w_acc;
      w_acc = {8'd0, p[15:11], 3'd0} * R_COEF
            + {8'd0, p[10:5], 2'd0} * G_COEF
            + {8'd0, p[4:0], 3'd0} * B_COEF;
      return 8'(w_acc >> 8);
   endfunction

   function automatic logic [7:0] abs_diff(
      input logic [7:0] a,
      input logic [7:0] b
   );
      return (a > b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/edge_line_buf.sv
// One-line gray buffer, IMG_W x 8, single port, read-before-write.
// Ports: clk, i_we, i_addr, i_wdata, o_rdata (registered read).
module edge_line_buf #(
   parameter int IMG_W = 640,
   parameter int AW    = $clog2(IMG_W)
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_addr,
   input  logic [7:0]    i_wdata,
   output logic [7:0]    o_rdata
);

   logic [7:0] r_mem [IMG_W];

   // No reset: contents are masked downstream on line 0.
   always_ff @(posedge clk) begin
      o_rdata <= r_mem[i_addr];
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

endmodule

// File: rtl/edge_detect_2d.sv
// Streaming RGB565 edge detector: gray, H/V gradient, threshold.
// Ports: clk, rst_n, s_valid/s_pixel/s_sof in, threshold, mode,
// m_valid/m_pixel/m_sof/m_eol out. Latency 2, no backpressure.
// Optional macro EDGE_GRAD_OUT_EN: edge pixels carry magnitude.
module edge_detect_2d
   import edge_pkg::*;
#(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int THR_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s_valid,
   input  logic [15:0]      s_pixel,
   input  logic             s_sof,
   input  logic [THR_W-1:0] threshold,
   input  logic [1:0]       mode,
   output logic             m_valid,
   output logic [15:0]      m_pixel,
   output logic             m_sof,
   output logic             m_eol
);

   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);
   localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

   logic [XW-1:0] r_x;
   logic [YW-1:0] r_y;
   logic [7:0]    r_left;
   s1_t           r_s1;

   logic [XW-1:0] w_x;
   logic [YW-1:0] w_y;
   logic [7:0]    w_gray;
   logic [7:0]    w_above;
   logic          w_x0;
   logic          w_y0;

   // s_sof overrides the counters for the pixel it marks.
   assign w_gray = rgb_to_gray(s_pixel);
   assign w_x    = s_sof ? '0 : r_x;
   assign w_y    = s_sof ? '0 : r_y;
   assign w_x0   = (w_x == '0);
   assign w_y0   = (w_y == '0);

   edge_line_buf #(
      .IMG_W (IMG_W),
      .AW    (XW)
   ) u_line_buf (
      .clk     (clk),
      .i_we    (s_valid),
      .i_addr  (w_x),
      .i_wdata (w_gray),
      .o_rdata (w_above)
   );

   // Stage 1 and position counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x    <= '0;
         r_y    <= '0;
         r_left <= '0;
         r_s1   <= '0;
      end else begin
         r_s1.valid <= s_valid;
         if (s_valid) begin
            r_s1.gray <= w_gray;
            r_s1.left <= r_left;
            r_s1.x0   <= w_x0;
            r_s1.y0   <= w_y0;
            r_s1.sof  <= w_x0 && w_y0;
            r_s1.eol  <= (w_x == X_LAST);
            r_left    <= w_gray;
            if (w_x == X_LAST) begin
               r_x <= '0;
               r_y <= (w_y == Y_LAST) ? '0 : w_y + 1'b1;
            end else begin
               r_x <= w_x + 1'b1;
               r_y <= w_y;
            end
         end
      end
   end

   logic [7:0]  w_h;
   logic [7:0]  w_v;
   logic [8:0]  w_sum;
   logic [7:0]  w_mag;
   logic        w_edge;
   logic [15:0] w_pix_edge;
   logic [15:0] w_pix;

   assign w_h = r_s1.x0 ? 8'd0
              : abs_diff(r_s1.gray, r_s1.left);
   assign w_v = r_s1.y0 ? 8'd0
              : abs_diff(r_s1.gray, w_above);
   assign w_sum = {1'b0, w_h} + {1'b0, w_v};

   always_comb begin
      w_mag = 8'd0;
      unique case (mode_e'(mode))
         MODE_H:   w_mag = w_h;
         MODE_V:   w_mag = w_v;
         MODE_SUM: w_mag = w_sum[8] ? 8'hFF : w_sum[7:0];
         MODE_MAX: w_mag = (w_h > w_v) ? w_h : w_v;
      endcase
   end

   assign w_edge = (w_mag > 8'(threshold));

`ifdef EDGE_GRAD_OUT_EN
   assign w_pix_edge = {w_mag[7:3], w_mag[7:2], w_mag[7:3]};
`else
   assign w_pix_edge = PIX_WHITE;
`endif

   assign w_pix = w_edge ? w_pix_edge : PIX_BLACK;

   // Stage 2: registered outputs, flags cleared on bubbles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid <= 1'b0;
         m_pixel <= PIX_BLACK;
         m_sof   <= 1'b0;
         m_eol   <= 1'b0;
      end else begin
         m_valid <= r_s1.valid;
         m_pixel <= r_s1.valid ? w_pix : PIX_BLACK;
         m_sof   <= r_s1.valid && r_s1.sof;
         m_eol   <= r_s1.valid && r_s1.eol;
      end
   end

endmodule
